tt_pad_cfg_seq: RTL and testbench

//  Owns the control bits of NUM_PADS bidirectional pad cells: OE, IE, SL, CS, PD and PU.

---
 rtl/tt_pad_cfg_seq.sv | 194 +++++++++++++++++++
 tb/tb_tt_pad_cfg_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_pad_cfg_seq.sv
// tt_pad_cfg_seq: glitch-safe sequencer for pad-cell control bits.
// One write at a time: driver off, settle, static bits, settle, driver on.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   cfg_valid  request valid
//   cfg_ready  idle, request can be taken this edge
//   cfg_idx    target pad index
//   cfg_data   {PU,PD,CS,SL,IE,OE}, bit 5 .. bit 0
//   cfg_err    one-cycle pulse after a bad index or PU/PD clash
//   busy       inverse of cfg_ready
//   pad_oe     per-pad output enable
//   pad_ie     per-pad input enable
//   pad_sl     per-pad slew select
//   pad_cs     per-pad Schmitt select
//   pad_pd     per-pad pull-down
//   pad_pu     per-pad pull-up
module tt_pad_cfg_seq #(
    parameter int NUM_PADS      = 8,
    parameter int IDX_W         = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [5:0]          cfg_data,
    output logic                cfg_err,
    output logic                busy,
    output logic [NUM_PADS-1:0] pad_oe,
    output logic [NUM_PADS-1:0] pad_ie,
    output logic [NUM_PADS-1:0] pad_sl,
    output logic [NUM_PADS-1:0] pad_cs,
    output logic [NUM_PADS-1:0] pad_pd,
    output logic [NUM_PADS-1:0] pad_pu
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT1  = 3'd1;
    localparam logic [2:0] ST_APPLY  = 3'd2;
    localparam logic [2:0] ST_WAIT2  = 3'd3;
    localparam logic [2:0] ST_DRV_ON = 3'd4;

    localparam int B_OE = 0;
    localparam int B_IE = 1;
    localparam int B_SL = 2;
    localparam int B_CS = 3;
    localparam int B_PD = 4;
    localparam int B_PU = 5;

    // Wait states load this and count down to zero, so each one
    // lasts exactly SETTLE_CYCLES cycles.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [2:0]          state;
    logic [2:0]          state_d;
    logic [7:0]          cnt;
    logic [7:0]          cnt_d;

    logic [NUM_PADS-1:0] sel_in;
    logic                idx_ok;
    logic                old_oe;
    logic                clash;
    logic [5:0]          data_fix;
    logic                accept;

    logic [NUM_PADS-1:0] mask_q;
    logic [5:0]          data_q;
    logic                bad_q;

    // One-hot decode of the requested index. An out-of-range index
    // decodes to all zeros, which keeps every pad untouched later.
    always_comb begin
        sel_in = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            sel_in[i] = (cfg_idx == IDX_W'(i));
        end
    end

    assign idx_ok = |sel_in;
    assign old_oe = |(pad_oe & sel_in);
    assign clash  = cfg_data[B_PU] & cfg_data[B_PD];
    assign accept = cfg_valid & cfg_ready;

    // Pull-up and pull-down together would fight; pull-down wins.
    always_comb begin
        data_fix = cfg_data;
        if (clash) begin
            data_fix[B_PU] = 1'b0;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (idx_ok && old_oe) begin
                        state_d = ST_WAIT1;
                        cnt_d   = SETTLE_LAST;
                    end else begin
                        // A bad index still spends one cycle in APPLY
                        // so busy covers the error pulse.
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_WAIT1: begin
                if (cnt == 8'd0) begin
                    state_d = ST_APPLY;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            ST_APPLY: begin
                if (!bad_q && data_q[B_OE]) begin
                    state_d = ST_WAIT2;
                    cnt_d   = SETTLE_LAST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT2: begin
                if (cnt == 8'd0) begin
                    state_d = ST_DRV_ON;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            ST_DRV_ON: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
            mask_q    <= '0;
            data_q    <= '0;
            bad_q     <= 1'b0;
            pad_oe    <= '0;
            pad_ie    <= '1;
            pad_sl    <= '0;
            pad_cs    <= '0;
            pad_pd    <= '1;
            pad_pu    <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            cfg_ready <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            cfg_err   <= accept & (~idx_ok | clash);

            if (accept) begin
                mask_q <= sel_in;
                data_q <= data_fix;
                bad_q  <= ~idx_ok;
                // Driver goes off on the accept edge itself.
                if (old_oe) begin
                    pad_oe <= pad_oe & ~sel_in;
                end
            end

            if (state == ST_APPLY && !bad_q) begin
                pad_ie <= (pad_ie & ~mask_q)
                        | ({NUM_PADS{data_q[B_IE]}} & mask_q);
                pad_sl <= (pad_sl & ~mask_q)
                        | ({NUM_PADS{data_q[B_SL]}} & mask_q);
                pad_cs <= (pad_cs & ~mask_q)
                        | ({NUM_PADS{data_q[B_CS]}} & mask_q);
                pad_pd <= (pad_pd & ~mask_q)
                        | ({NUM_PADS{data_q[B_PD]}} & mask_q);
                pad_pu <= (pad_pu & ~mask_q)
                        | ({NUM_PADS{data_q[B_PU]}} & mask_q);
            end

            if (state == ST_DRV_ON) begin
                pad_oe <= pad_oe | mask_q;
            end
        end
    end

endmodule

// File: tb/tb_tt_pad_cfg_seq.sv
// Directed bench for tt_pad_cfg_seq with SETTLE_CYCLES=4, 8 pads,
// and a 4-bit index so out-of-range requests can be issued.
module tb_tt_pad_cfg_seq;

    logic       clk;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_idx;
    logic [5:0] cfg_data;
    logic       cfg_err;
    logic       busy;
    logic [7:0] pad_oe;
    logic [7:0] pad_ie;
    logic [7:0] pad_sl;
    logic [7:0] pad_cs;
    logic [7:0] pad_pd;
    logic [7:0] pad_pu;

    int n_checks;
    int n_fail;

    tt_pad_cfg_seq #(
        .NUM_PADS      (8),
        .IDX_W         (4),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .pad_oe    (pad_oe),
        .pad_ie    (pad_ie),
        .pad_sl    (pad_sl),
        .pad_cs    (pad_cs),
        .pad_pd    (pad_pd),
        .pad_pu    (pad_pu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pads(input string tag,
                              input logic [7:0] oe,
                              input logic [7:0] ie,
                              input logic [7:0] sl,
                              input logic [7:0] cs,
                              input logic [7:0] pd,
                              input logic [7:0] pu);
        check({tag, ".oe"}, {24'd0, pad_oe}, {24'd0, oe});
        check({tag, ".ie"}, {24'd0, pad_ie}, {24'd0, ie});
        check({tag, ".sl"}, {24'd0, pad_sl}, {24'd0, sl});
        check({tag, ".cs"}, {24'd0, pad_cs}, {24'd0, cs});
        check({tag, ".pd"}, {24'd0, pad_pd}, {24'd0, pd});
        check({tag, ".pu"}, {24'd0, pad_pu}, {24'd0, pu});
    endtask

    task automatic check_hs(input string tag,
                            input logic rdy,
                            input logic err);
        check({tag, ".ready"}, {31'd0, cfg_ready}, {31'd0, rdy});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, ~rdy});
        check({tag, ".err"}, {31'd0, cfg_err}, {31'd0, err});
    endtask

    // Presents a request and returns 1ns after the accept edge E0.
    task automatic send(input logic [3:0] idx, input logic [5:0] data);
        cfg_valid = 1'b1;
        cfg_idx   = idx;
        cfg_data  = data;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_idx   = '0;
        cfg_data  = '0;

        // 1: reset values
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_pads("rst", 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00);
        check_hs("rst", 1'b1, 1'b0);

        // 2: pad 2, IE+OE, old OE=0
        send(4'd2, 6'b000011);
        check_hs("s2_e0", 1'b0, 1'b0);
        check_pads("s2_e0", 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00);
        tick();
        check_pads("s2_e1", 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFB, 8'h00);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check("s2_oe_wait", {24'd0, pad_oe}, 32'h00);
            check("s2_busy", {31'd0, cfg_ready}, 32'd0);
        end
        tick();
        check_pads("s2_e6", 8'h04, 8'hFF, 8'h00, 8'h00, 8'hFB, 8'h00);
        check_hs("s2_e6", 1'b1, 1'b0);

        // 3: pad 2 again with PU, old OE=1
        send(4'd2, 6'b100011);
        check_pads("s3_e0", 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFB, 8'h00);
        check_hs("s3_e0", 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_pads("s3_seq",
                       (k >= 10) ? 8'h04 : 8'h00,
                       8'hFF, 8'h00, 8'h00, 8'hFB,
                       (k >= 5) ? 8'h04 : 8'h00);
            check("s3_ready", {31'd0, cfg_ready},
                  (k >= 10) ? 32'd1 : 32'd0);
        end

        // 4a: out-of-range index
        send(4'd9, 6'b000001);
        check_hs("s4a_e0", 1'b0, 1'b1);
        check_pads("s4a_e0", 8'h04, 8'hFF, 8'h00, 8'h00, 8'hFB, 8'h04);
        tick();
        check_hs("s4a_e1", 1'b1, 1'b0);
        check_pads("s4a_e1", 8'h04, 8'hFF, 8'h00, 8'h00, 8'hFB, 8'h04);

        // 4b: PU and PD together on pad 5
        send(4'd5, 6'b110000);
        check_hs("s4b_e0", 1'b0, 1'b1);
        tick();
        check_hs("s4b_e1", 1'b1, 1'b0);
        check_pads("s4b_e1", 8'h04, 8'hDF, 8'h00, 8'h00, 8'hFB, 8'h04);

        // 5: reset in the middle of a pad-2 sequence
        send(4'd2, 6'b100011);
        check("s5_oe_off", {24'd0, pad_oe}, 32'h00);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_pads("s5_rst", 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00);
        check_hs("s5_rst", 1'b1, 1'b0);
        rst_n = 1'b1;
        tick();
        check_hs("s5_post", 1'b1, 1'b0);

        // 6: valid held high; second request waits for idle
        cfg_valid = 1'b1;
        cfg_idx   = 4'd1;
        cfg_data  = 6'b000101;
        tick();
        cfg_idx   = 4'd3;
        cfg_data  = 6'b011010;
        check_hs("s6_e0", 1'b0, 1'b0);
        tick();
        check_pads("s6_e1", 8'h00, 8'hFD, 8'h04 >> 1, 8'h00, 8'hFD, 8'h00);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check_pads("s6_hold", 8'h00, 8'hFD, 8'h02, 8'h00, 8'hFD, 8'h00);
            check("s6_ready", {31'd0, cfg_ready}, 32'd0);
        end
        tick();
        check_pads("s6_e6", 8'h02, 8'hFD, 8'h02, 8'h00, 8'hFD, 8'h00);
        check_hs("s6_e6", 1'b1, 1'b0);
        tick();
        check_hs("s6_b_e0", 1'b0, 1'b0);
        cfg_valid = 1'b0;
        tick();
        check_pads("s6_b_e1", 8'h02, 8'hFD, 8'h02, 8'h08, 8'hFD, 8'h00);
        check_hs("s6_b_e1", 1'b1, 1'b0);
        tick();
        check_pads("s6_idle", 8'h02, 8'hFD, 8'h02, 8'h08, 8'hFD, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
